// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header insert/extract stages:
// FSM state encoding and byte/bit shift helpers.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH
    } hdr_state_t;

    localparam int BYTE_WD    = 8;
    localparam int BYTE_SHIFT = 3;

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// AXI-Stream bundle used on the header-extract ports; the header port leaves tlast tied high.
interface axi_stream_extract_header_if #(
    parameter int DATA_WD = 32
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    logic                    tvalid;
    logic [DATA_WD-1:0]      tdata;
    logic [DATA_BYTE_WD-1:0] tkeep;
    logic                    tlast;
    logic                    tready;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axis_keep_popcount.sv
// Counts the set bits of a tkeep vector, giving the number of valid bytes in a beat.
module axis_keep_popcount #(
    parameter int BYTES  = 4,
    parameter int CNT_WD = $clog2(BYTES + 1)
) (
    input  logic [BYTES-1:0]  keep,
    output logic [CNT_WD-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BYTES; i++) begin
            count = count + CNT_WD'(keep[i]);
        end
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Splits the first H bytes of each packet onto a one-beat header port and re-aligns the payload.
// Optional macro AXIS_EXTRACT_HDR_ERR_EN adds the err_short short-packet pulse output.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(DATA_BYTE_WD+1)-1:0] cfg_hdr_bytes,
    axi_stream_extract_header_if.slave        s_axis,
    axi_stream_extract_header_if.master       m00_axis,
    axi_stream_extract_header_if.master       m01_axis
`ifdef AXIS_EXTRACT_HDR_ERR_EN
    ,
    output logic                              err_short
`endif
);

    localparam int B  = DATA_BYTE_WD;
    localparam int CW = $clog2(B + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [DATA_WD-1:0] data_t;
    typedef logic [B-1:0] keep_t;

    function automatic keep_t top_keep(input cnt_t n);
        keep_t ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    function automatic keep_t low_keep(input cnt_t n);
        keep_t ones;
        ones = '1;
        return ~(ones << n);
    endfunction

    function automatic logic [CW+BYTE_SHIFT-1:0] byte_bits(input cnt_t n);
        return {n, {BYTE_SHIFT{1'b0}}};
    endfunction

    hdr_state_t state, state_nxt;
    cnt_t       hdr_len, hdr_len_nxt;
    cnt_t       flush_cnt, flush_cnt_nxt;
    data_t      res_data, res_nxt;

    logic  m00_valid, m00_valid_nxt;
    data_t m00_data, m00_data_nxt;
    keep_t m00_keep, m00_keep_nxt;
    logic  m01_valid, m01_valid_nxt;
    data_t m01_data, m01_data_nxt;
    keep_t m01_keep, m01_keep_nxt;
    logic  m01_last, m01_last_nxt;

    cnt_t  in_cnt;
    cnt_t  cfg_clamped;
    cnt_t  h_cur;
    cnt_t  r_cur;
    cnt_t  hdr_take;
    data_t beat;
    data_t joined;
    logic  m00_free;
    logic  m01_free;
    logic  s_ready;
    logic  accept;

    axis_keep_popcount #(.BYTES(B), .CNT_WD(CW)) u_popcount (
        .keep  (s_axis.tkeep),
        .count (in_cnt)
    );

    // Bytes outside tkeep are zeroed so they never leak into re-aligned output beats.
    always_comb begin
        beat = '0;
        for (int i = 0; i < B; i++) begin
            beat[i*BYTE_WD +: BYTE_WD] = s_axis.tdata[i*BYTE_WD +: BYTE_WD] & {BYTE_WD{s_axis.tkeep[i]}};
        end
    end

    assign cfg_clamped = (cfg_hdr_bytes > cnt_t'(B)) ? cnt_t'(B) : cfg_hdr_bytes;
    assign h_cur       = (state == ST_IDLE) ? cfg_clamped : hdr_len;
    assign r_cur       = cnt_t'(B) - h_cur;
    assign hdr_take    = (in_cnt < h_cur) ? in_cnt : h_cur;
    assign joined      = res_data | (beat >> byte_bits(r_cur));

    assign m00_free = !m00_valid || m00_axis.tready;
    assign m01_free = !m01_valid || m01_axis.tready;
    assign s_ready  = m01_free && (state != ST_FLUSH) && ((state != ST_IDLE) || m00_free);
    assign accept   = s_axis.tvalid && s_ready;

    always_comb begin
        state_nxt     = state;
        hdr_len_nxt   = hdr_len;
        flush_cnt_nxt = flush_cnt;
        res_nxt       = res_data;
        m00_valid_nxt = m00_valid && !m00_axis.tready;
        m00_data_nxt  = m00_data;
        m00_keep_nxt  = m00_keep;
        m01_valid_nxt = m01_valid && !m01_axis.tready;
        m01_data_nxt  = m01_data;
        m01_keep_nxt  = m01_keep;
        m01_last_nxt  = m01_last;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    hdr_len_nxt = h_cur;
                    res_nxt     = beat << byte_bits(h_cur);
                    if (hdr_take != '0) begin
                        m00_valid_nxt = 1'b1;
                        m00_data_nxt  = beat >> byte_bits(cnt_t'(B) - hdr_take);
                        m00_keep_nxt  = low_keep(hdr_take);
                    end
                    if (s_axis.tlast) begin
                        if (in_cnt > h_cur) begin
                            m01_valid_nxt = 1'b1;
                            m01_data_nxt  = beat << byte_bits(h_cur);
                            m01_keep_nxt  = top_keep(in_cnt - h_cur);
                            m01_last_nxt  = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    m01_valid_nxt = 1'b1;
                    m01_data_nxt  = joined;
                    res_nxt       = beat << byte_bits(hdr_len);
                    if (!s_axis.tlast) begin
                        m01_keep_nxt = '1;
                        m01_last_nxt = 1'b0;
                    end else if (in_cnt <= hdr_len) begin
                        m01_keep_nxt = top_keep(r_cur + in_cnt);
                        m01_last_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end else begin
                        // Tail spills past this beat: emit a full beat now, the rest from FLUSH.
                        m01_keep_nxt  = '1;
                        m01_last_nxt  = 1'b0;
                        flush_cnt_nxt = in_cnt - hdr_len;
                        state_nxt     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (m01_free) begin
                    m01_valid_nxt = 1'b1;
                    m01_data_nxt  = res_data;
                    m01_keep_nxt  = top_keep(flush_cnt);
                    m01_last_nxt  = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hdr_len   <= '0;
            flush_cnt <= '0;
            res_data  <= '0;
            m00_valid <= 1'b0;
            m00_data  <= '0;
            m00_keep  <= '0;
            m01_valid <= 1'b0;
            m01_data  <= '0;
            m01_keep  <= '0;
            m01_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hdr_len   <= hdr_len_nxt;
            flush_cnt <= flush_cnt_nxt;
            res_data  <= res_nxt;
            m00_valid <= m00_valid_nxt;
            m00_data  <= m00_data_nxt;
            m00_keep  <= m00_keep_nxt;
            m01_valid <= m01_valid_nxt;
            m01_data  <= m01_data_nxt;
            m01_keep  <= m01_keep_nxt;
            m01_last  <= m01_last_nxt;
        end
    end

`ifdef AXIS_EXTRACT_HDR_ERR_EN
    // Rises together with the short header beat's valid and clears on the next edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_short <= 1'b0;
        end else begin
            err_short <= accept && (state == ST_IDLE) && s_axis.tlast && (in_cnt < h_cur);
        end
    end
`endif

    assign s_axis.tready   = s_ready;
    assign m00_axis.tvalid = m00_valid;
    assign m00_axis.tdata  = m00_data;
    assign m00_axis.tkeep  = m00_keep;
    assign m00_axis.tlast  = 1'b1;
    assign m01_axis.tvalid = m01_valid;
    assign m01_axis.tdata  = m01_data;
    assign m01_axis.tkeep  = m01_keep;
    assign m01_axis.tlast  = m01_last;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed self-checking bench for axi_stream_extract_header (B=4); honours AXIS_EXTRACT_HDR_ERR_EN.
module tb_axi_stream_extract_header;

    localparam int DATA_WD = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cfg_hdr_bytes;
    int         compared   = 0;
    int         mismatched = 0;
    int         err_cnt    = 0;

    logic [35:0] hdr_q[$];
    logic [36:0] pay_q[$];

    axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) s_axis_if ();
    axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) m00_axis_if ();
    axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) m01_axis_if ();

`ifdef AXIS_EXTRACT_HDR_ERR_EN
    logic err_short;
`endif

    axi_stream_extract_header #(.DATA_WD(DATA_WD)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_hdr_bytes (cfg_hdr_bytes),
        .s_axis        (s_axis_if),
        .m00_axis      (m00_axis_if),
        .m01_axis      (m01_axis_if)
`ifdef AXIS_EXTRACT_HDR_ERR_EN
        ,
        .err_short     (err_short)
`endif
    );

    always #5 clk = ~clk;

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (m00_axis_if.tvalid && m00_axis_if.tready)
                hdr_q.push_back({m00_axis_if.tdata, m00_axis_if.tkeep});
            if (m01_axis_if.tvalid && m01_axis_if.tready)
                pay_q.push_back({m01_axis_if.tdata, m01_axis_if.tkeep, m01_axis_if.tlast});
`ifdef AXIS_EXTRACT_HDR_ERR_EN
            if (err_short) err_cnt++;
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last);
        bit done;
        done = 1'b0;
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = data;
        s_axis_if.tkeep  = keep;
        s_axis_if.tlast  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_axis_if.tready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: observed no tready required tready for beat %h", data);
        end
        @(posedge clk);
        #1;
        s_axis_if.tvalid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectHeader(input string tag, input logic [31:0] d, input logic [3:0] k);
        logic [35:0] obs;
        obs = 'x;
        if (hdr_q.size() > 0) obs = hdr_q.pop_front();
        checkOutput(tag, 64'(obs), 64'({d, k}));
    endtask

    task automatic expectPayload(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        logic [36:0] obs;
        obs = 'x;
        if (pay_q.size() > 0) obs = pay_q.pop_front();
        checkOutput(tag, 64'(obs), 64'({d, k, l}));
    endtask

    task automatic expectCounts(input string tag, input int nh, input int np);
        checkOutput({tag, "_hdr_cnt"}, 64'(hdr_q.size()), 64'(nh));
        checkOutput({tag, "_pay_cnt"}, 64'(pay_q.size()), 64'(np));
    endtask

    initial begin
        rst                = 1'b0;
        cfg_hdr_bytes      = 3'd2;
        s_axis_if.tvalid   = 1'b0;
        s_axis_if.tdata    = '0;
        s_axis_if.tkeep    = '0;
        s_axis_if.tlast    = 1'b0;
        m00_axis_if.tready = 1'b1;
        m01_axis_if.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m00_valid", 64'(m00_axis_if.tvalid), 64'(0));
        checkOutput("rst_m01_valid", 64'(m01_axis_if.tvalid), 64'(0));
        checkOutput("rst_m01_data",  64'(m01_axis_if.tdata),  64'(0));
        checkOutput("rst_m01_last",  64'(m01_axis_if.tlast),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_s_ready", 64'(s_axis_if.tready), 64'(1));
        idleCycles(1);

        // H=2 basic packet
        cfg_hdr_bytes = 3'd2;
        applyStimulus(32'hAABBCCDD, 4'hF, 1'b0);
        applyStimulus(32'h11223344, 4'hF, 1'b0);
        applyStimulus(32'h55660000, 4'hC, 1'b1);
        idleCycles(3);
        expectCounts("h2", 1, 2);
        expectHeader("h2_hdr", 32'h0000AABB, 4'h3);
        expectPayload("h2_p0", 32'hCCDD1122, 4'hF, 1'b0);
        expectPayload("h2_p1", 32'h33445566, 4'hF, 1'b1);

        // H=1 with flush beat
        cfg_hdr_bytes = 3'd1;
        applyStimulus(32'hAABBCCDD, 4'hF, 1'b0);
        applyStimulus(32'h11223300, 4'hE, 1'b1);
        @(negedge clk);
        checkOutput("h1_flush_tready", 64'(s_axis_if.tready), 64'(0));
        idleCycles(3);
        expectCounts("h1", 1, 2);
        expectHeader("h1_hdr", 32'h000000AA, 4'h1);
        expectPayload("h1_p0", 32'hBBCCDD11, 4'hF, 1'b0);
        expectPayload("h1_p1", 32'h22330000, 4'hC, 1'b1);

        // H=3 short packet
        cfg_hdr_bytes = 3'd3;
        applyStimulus(32'hAABB0000, 4'hC, 1'b1);
        idleCycles(3);
        expectCounts("h3", 1, 0);
        expectHeader("h3_hdr", 32'h0000AABB, 4'h3);
`ifdef AXIS_EXTRACT_HDR_ERR_EN
        checkOutput("h3_err_pulses", 64'(err_cnt), 64'(1));
`endif

        // H=0 pass-through
        cfg_hdr_bytes = 3'd0;
        applyStimulus(32'h01020304, 4'hF, 1'b0);
        applyStimulus(32'h05060708, 4'hF, 1'b0);
        applyStimulus(32'h090A0B0C, 4'hF, 1'b1);
        idleCycles(4);
        expectCounts("h0", 0, 3);
        expectPayload("h0_p0", 32'h01020304, 4'hF, 1'b0);
        expectPayload("h0_p1", 32'h05060708, 4'hF, 1'b0);
        expectPayload("h0_p2", 32'h090A0B0C, 4'hF, 1'b1);

        // H=4 whole first beat is header
        cfg_hdr_bytes = 3'd4;
        applyStimulus(32'h01020304, 4'hF, 1'b0);
        applyStimulus(32'h05060708, 4'hF, 1'b0);
        applyStimulus(32'h090A0000, 4'hC, 1'b1);
        idleCycles(3);
        expectCounts("h4", 1, 2);
        expectHeader("h4_hdr", 32'h01020304, 4'hF);
        expectPayload("h4_p0", 32'h05060708, 4'hF, 1'b0);
        expectPayload("h4_p1", 32'h090A0000, 4'hC, 1'b1);

        // H=6 clamps to 4; single full beat is header only
        cfg_hdr_bytes = 3'd6;
        applyStimulus(32'h0A0B0C0D, 4'hF, 1'b1);
        idleCycles(3);
        expectCounts("clamp", 1, 0);
        expectHeader("clamp_hdr", 32'h0A0B0C0D, 4'hF);

        // Backpressure on payload port mid-packet
        cfg_hdr_bytes = 3'd2;
        applyStimulus(32'hA1A2A3A4, 4'hF, 1'b0);
        applyStimulus(32'hB1B2B3B4, 4'hF, 1'b0);
        m01_axis_if.tready = 1'b0;
        s_axis_if.tvalid   = 1'b1;
        s_axis_if.tdata    = 32'hC1C2C3C4;
        s_axis_if.tkeep    = 4'hF;
        s_axis_if.tlast    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_s_ready",   64'(s_axis_if.tready),   64'(0));
            checkOutput("bp_m01_valid", 64'(m01_axis_if.tvalid), 64'(1));
            checkOutput("bp_m01_data",  64'(m01_axis_if.tdata),  64'(32'hA3A4B1B2));
            @(posedge clk);
            #1;
        end
        m01_axis_if.tready = 1'b1;
        applyStimulus(32'hC1C2C3C4, 4'hF, 1'b0);
        applyStimulus(32'hD1D2D3D4, 4'hF, 1'b1);
        idleCycles(4);
        expectCounts("bp", 1, 4);
        expectHeader("bp_hdr", 32'h0000A1A2, 4'h3);
        expectPayload("bp_p0", 32'hA3A4B1B2, 4'hF, 1'b0);
        expectPayload("bp_p1", 32'hB3B4C1C2, 4'hF, 1'b0);
        expectPayload("bp_p2", 32'hC3C4D1D2, 4'hF, 1'b0);
        expectPayload("bp_p3", 32'hD3D40000, 4'hC, 1'b1);

        // Reset in STREAM, then a fresh H=2 packet
        applyStimulus(32'h12345678, 4'hF, 1'b0);
        applyStimulus(32'h9ABCDEF0, 4'hF, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_m00_valid", 64'(m00_axis_if.tvalid), 64'(0));
        checkOutput("mid_rst_m01_valid", 64'(m01_axis_if.tvalid), 64'(0));
        hdr_q.delete();
        pay_q.delete();
        idleCycles(1);
        applyStimulus(32'h10203040, 4'hF, 1'b0);
        applyStimulus(32'h50607080, 4'hC, 1'b1);
        idleCycles(3);
        expectCounts("post_rst", 1, 1);
        expectHeader("post_rst_hdr", 32'h00001020, 4'h3);
        expectPayload("post_rst_p0", 32'h30405060, 4'hF, 1'b1);

`ifdef AXIS_EXTRACT_HDR_ERR_EN
        checkOutput("err_total", 64'(err_cnt), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Downstream counterpart of the header-insertion stage. Splits the first `cfg_hdr_bytes` bytes of each incoming AXI-Stream packet onto a one-beat header port. Re-aligns the remaining payload to beat boundaries on a payload port, so an insert→extract round trip restores the original header and data streams. Byte order is MSB-first: stream byte 0 is `tdata[DATA_WD-1 -: 8]` / `tkeep[DATA_BYTE_WD-1]`. Payload `tkeep` is always contiguous from the MSB.

## Interface
- `DATA_WD`, 32, data width in bits (multiple of 8)
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat (B)
- `clk` in 1: single clock
- `rst` in 1: **synchronous, active-low** reset
- `cfg_hdr_bytes` in `$clog2(B+1)`: header length H in bytes; sampled when the first beat of a packet is accepted; values > B clamp to B
- `s_axis_tvalid`/`tdata`/`tkeep`/`tlast`/`tready` in/in/in/in/out, widths 1/DATA_WD/B/1/1: packet input (header already inserted)
- `m00_axis_tvalid`/`tdata`/`tkeep`/`tready` out/out/out/in, widths 1/DATA_WD/B/1: extracted header, right-aligned, `tkeep` low-order bits set
- `m01_axis_tvalid`/`tdata`/`tkeep`/`tlast`/`tready` out/out/out/out/in, widths 1/DATA_WD/B/1/1: payload stream
- `err_short` out 1: short-packet pulse (present only with the macro)

## Operation
- **States:**
  - IDLE: awaiting the first beat.
  - STREAM: mid-packet.
  - FLUSH: emitting the residue after `tlast`.
- **First beat accepted in IDLE:**
  - Latch H.
  - Top H bytes go to `m00` (header beat).
  - Bytes H..B-1 go to the residue register, R = B-H bytes.
  - → STREAM; if `tlast`, handled per the rules below.
- **STREAM, non-last beat with k = B:** output = residue ‖ top H bytes of the beat, with `tkeep` all ones. The new residue is the beat's low B-H bytes.
- **Last beat with k valid bytes:**
  - k ≤ H: a single output beat, `tkeep` = top (B-H+k) bits, `tlast`=1; → IDLE.
  - k > H: a full beat, then → FLUSH.
  - FLUSH emits the remaining k-H bytes MSB-aligned with `tlast`=1; → IDLE.
- **First beat also `tlast`:**
  - k > H: header beat plus one payload beat of k-H bytes with `tlast`.
  - k = H: header beat only; no payload beat.
  - k < H (short): header beat carries the k available bytes, right-aligned, `tkeep` low k bits set; no payload beat.
- **H = 0:** no header beat; payload passes through unshifted.
- **H = B:** the whole first beat is the header; subsequent beats pass through unshifted.
- Byte counts are computed by popcount of `tkeep`. Inputs must have contiguous MSB-aligned `tkeep`; any other pattern is undefined.

## Timing
- All outputs are registered. First output appears 1 cycle after input acceptance.
- Throughput is 1 beat/cycle. A FLUSH beat costs one extra cycle, during which `s_axis_tready`=0.
- `s_axis_tready` = (!`m01_axis_tvalid` | `m01_axis_tready`) & (state≠FLUSH) & (state≠IDLE | !`m00_axis_tvalid` | `m00_axis_tready`).
  - Combinational from the ready inputs; no combinational path from `s_axis_tvalid`.
- **Output holding:** `m00`/`m01` hold data/keep/last stable while valid & !ready. Valid never drops without a handshake.
- **Reset:** `rst`=0 sampled at a clock edge forces:
  - all valids 0, all data/keep 0, `m01_axis_tlast` 0, `err_short` 0;
  - state IDLE, residue discarded.
  - Reset mid-packet drops that packet; the next accepted beat is a first beat.
- **Simultaneous events:** output acceptance and input acceptance in the same cycle are both honoured; the register is reloaded without a bubble.

## Configuration
- `AXIS_EXTRACT_HDR_ERR_EN` defined:
  - the `err_short` port exists;
  - it pulses 1 for exactly one cycle, on the cycle the short header beat becomes valid.
  - Data behaviour is unchanged.
- Undefined: the port and logic are absent; short packets are handled silently as above.

## Structure
- **Shared package `axis_hdr_pkg`:**
  - state enum (IDLE/STREAM/FLUSH);
  - byte-shift helper constants;
  - shared with the insertion stage.
- **Sub-module `axis_keep_popcount`:** `tkeep` → byte count; the insertion stage reuses it.

## Test plan (B=4)
- **H=2, basic packet:**
  - Stimulus: beats 0xAABBCCDD/F, 0x11223344/F, 0x5566xxxx/C last.
  - Required: header 0x0000AABB/3; payload 0xCCDD1122/F, then 0x33445566/F last.
- **H=1, flush case:**
  - Stimulus: beats 0xAABBCCDD/F, 0x112233xx/E last.
  - Required: header 0x000000AA/1; payload 0xBBCCDD11/F, then 0x2233xxxx/C last; `s_axis_tready` low during the flush cycle.
- **H=3, short packet:**
  - Stimulus: single beat 0xAABBxxxx/C last.
  - Required: header 0x0000AABB/3; no payload beat; `err_short` pulses once with the macro, no port without it.
- **H=0 and H=4:**
  - H=0: a 3-beat packet passes through unchanged; no header beat.
  - H=4: header = beat 0 (keep F); remaining beats pass unchanged.
- **Backpressure:**
  - Stimulus: `m01_axis_tready`=0 for 3 cycles mid-packet.
  - Required: `s_axis_tready`=0, outputs held stable, no byte lost or duplicated.
- **Reset mid-packet:**
  - Stimulus: `rst`=0 for one cycle in STREAM.
  - Required: valids 0 next cycle; a following packet with H=2 produces correct header/payload.
